bf_loader: RTL and testbench

//  Program loader for the BF core's instruction write port. Accepts BF source text as
//  an ASCII byte stream (valid/ready), drops non-command characters, encodes the eight

---
 rtl/bf_loader.sv | 225 ++++++++++++++++++++++
 tb/tb_bf_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_loader.sv
// bf_loader: loads BF source text into the core's program memory.
// Filters an ASCII byte stream down to the eight BF commands, writes their
// 3-bit opcodes to consecutive program addresses with a one-cycle write
// strobe, checks bracket balance and capacity, and holds the core in reset
// until a complete, balanced program has been stored.
// Optional feature: define BF_LOADER_COMMENT_EN to treat '#' as the start
// of a comment that runs up to and including the next '\n'.
module bf_loader #(
   parameter int ADDR_W = 8,
   parameter int NEST_W = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [7:0]        char_in,
   input  logic              char_valid,
   output logic              char_ready,
   input  logic              src_end,
   output logic [ADDR_W-1:0] instr_addr,
   output logic [3:0]        instr_data,
   output logic              instr_write,
   output logic              cpu_reset,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   prog_len
);

   localparam logic [ADDR_W:0]   CAPACITY  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [NEST_W-1:0] MAX_DEPTH = {NEST_W{1'b1}};

   localparam logic [2:0] OP_OPEN  = 3'd6;
   localparam logic [2:0] OP_CLOSE = 3'd7;

   localparam logic [1:0] ERR_STRAY    = 2'b01;
   localparam logic [1:0] ERR_UNCLOSED = 2'b10;
   localparam logic [1:0] ERR_CAPACITY = 2'b11;

   typedef enum logic [2:0] {
      S_ACCEPT,
      S_SETUP,
      S_STROBE,
      S_DONE,
      S_ERROR
`ifdef BF_LOADER_COMMENT_EN
      , S_COMMENT
`endif
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [1:0]        w_next_code;
   logic [ADDR_W-1:0] r_addr;
   logic [2:0]        r_op;
   logic              r_write;
   logic [1:0]        r_err_code;
   logic [ADDR_W:0]   r_prog_len;
   logic [NEST_W-1:0] r_depth;
   logic              r_end_pending;

   logic              w_is_cmd;
   logic [2:0]        w_op;
   logic              w_char_ready;
   logic              w_hs;
   logic [NEST_W-1:0] w_depth_after;

   // Command decode of the incoming byte.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_is_cmd = 1'b1;
      w_op     = 3'd0;
      case (char_in)
         8'h3E:   w_op = 3'd0;  // '>'
         8'h3C:   w_op = 3'd1;  // '<'
         8'h2B:   w_op = 3'd2;  // '+'
         8'h2D:   w_op = 3'd3;  // '-'
         8'h2E:   w_op = 3'd4;  // '.'
         8'h2C:   w_op = 3'd5;  // ','
         8'h5B:   w_op = 3'd6;  // '['
         8'h5D:   w_op = 3'd7;  // ']'
         default: w_is_cmd = 1'b0;
      endcase
   end

`ifdef BF_LOADER_COMMENT_EN
   assign w_char_ready = (r_state == S_ACCEPT) || (r_state == S_COMMENT);
`else
   assign w_char_ready = (r_state == S_ACCEPT);
`endif
   assign w_hs = char_valid & w_char_ready;

   // Depth after the command currently being strobed has been committed.
   always_comb begin
      w_depth_after = r_depth;
      if (r_op == OP_OPEN)
         w_depth_after = r_depth + NEST_W'(1);
      else if (r_op == OP_CLOSE)
         w_depth_after = r_depth - NEST_W'(1);
   end

   // Next-state and error-code selection; start overrides everything.
   always_comb begin
      w_next_state = r_state;
      w_next_code  = r_err_code;
      if (start) begin
         w_next_state = S_ACCEPT;
      end else begin
         case (r_state)
            S_ACCEPT: begin
               if (w_hs && w_is_cmd) begin
                  // A rejected command is never written.
                  if (w_op == OP_CLOSE && r_depth == '0) begin
                     w_next_state = S_ERROR;
                     w_next_code  = ERR_STRAY;
                  end else if (w_op == OP_OPEN && r_depth == MAX_DEPTH) begin
                     w_next_state = S_ERROR;
                     w_next_code  = ERR_CAPACITY;
                  end else if (r_prog_len == CAPACITY) begin
                     w_next_state = S_ERROR;
                     w_next_code  = ERR_CAPACITY;
                  end else begin
                     w_next_state = S_SETUP;
                  end
               end else if (src_end) begin
                  if (r_depth != '0) begin
                     w_next_state = S_ERROR;
                     w_next_code  = ERR_UNCLOSED;
                  end else begin
                     w_next_state = S_DONE;
                  end
`ifdef BF_LOADER_COMMENT_EN
               end else if (w_hs && char_in == 8'h23) begin
                  w_next_state = S_COMMENT;
`endif
               end
            end
            S_SETUP: w_next_state = S_STROBE;
            S_STROBE: begin
               if (r_end_pending) begin
                  if (w_depth_after != '0) begin
                     w_next_state = S_ERROR;
                     w_next_code  = ERR_UNCLOSED;
                  end else begin
                     w_next_state = S_DONE;
                  end
               end else begin
                  w_next_state = S_ACCEPT;
               end
            end
`ifdef BF_LOADER_COMMENT_EN
            S_COMMENT: begin
               if (src_end) begin
                  if (r_depth != '0) begin
                     w_next_state = S_ERROR;
                     w_next_code  = ERR_UNCLOSED;
                  end else begin
                     w_next_state = S_DONE;
                  end
               end else if (w_hs && char_in == 8'h0A) begin
                  w_next_state = S_ACCEPT;
               end
            end
`endif
            S_DONE:  w_next_state = S_DONE;
            S_ERROR: w_next_state = S_ERROR;
            default: w_next_state = S_ACCEPT;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n)
         r_state <= S_ACCEPT;
      else
         r_state <= w_next_state;
   end

   // Datapath: write port, counters, end flag and sticky error code.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_addr        <= '0;
         r_op          <= '0;
         r_write       <= 1'b0;
         r_err_code    <= '0;
         r_prog_len    <= '0;
         r_depth       <= '0;
         r_end_pending <= 1'b0;
      end else if (start) begin
         r_addr        <= '0;
         r_op          <= '0;
         r_write       <= 1'b0;
         r_err_code    <= '0;
         r_prog_len    <= '0;
         r_depth       <= '0;
         r_end_pending <= 1'b0;
      end else begin
         // Strobe is a flop so the core sees a clean, glitch-free pulse.
         r_write <= (w_next_state == S_STROBE);
         if (r_state == S_ACCEPT && w_next_state == S_SETUP) begin
            r_addr        <= r_prog_len[ADDR_W-1:0];
            r_op          <= w_op;
            r_end_pending <= src_end;
         end
         if (r_state == S_STROBE) begin
            r_prog_len <= r_prog_len + (ADDR_W+1)'(1);
            r_depth    <= w_depth_after;
         end
         if (w_next_state == S_ERROR && r_state != S_ERROR)
            r_err_code <= w_next_code;
      end
   end

   assign char_ready  = w_char_ready;
   assign instr_addr  = r_addr;
   assign instr_data  = {1'b0, r_op};
   assign instr_write = r_write;
   assign cpu_reset   = (r_state != S_DONE);
   assign done        = (r_state == S_DONE);
   assign error       = (r_state == S_ERROR);
   assign err_code    = r_err_code;
   assign prog_len    = r_prog_len;

endmodule

// File: tb/tb_bf_loader.sv
// tb_bf_loader: directed test of bf_loader against a sequential source-text
// model (expected writes and final status derived per character), with a
// per-cycle write monitor and literal spot checks of the main scenarios.
module tb_bf_loader;

   localparam int ADDR_W = 8;
   localparam int NEST_W = 4;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic [7:0]        char_in = 8'h00;
   logic              char_valid = 1'b0;
   logic              char_ready;
   logic              src_end = 1'b0;
   logic [ADDR_W-1:0] instr_addr;
   logic [3:0]        instr_data;
   logic              instr_write;
   logic              cpu_reset;
   logic              done;
   logic              error;
   logic [1:0]        err_code;
   logic [ADDR_W:0]   prog_len;

   bf_loader #(.ADDR_W(ADDR_W), .NEST_W(NEST_W)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .char_in     (char_in),
      .char_valid  (char_valid),
      .char_ready  (char_ready),
      .src_end     (src_end),
      .instr_addr  (instr_addr),
      .instr_data  (instr_data),
      .instr_write (instr_write),
      .cpu_reset   (cpu_reset),
      .done        (done),
      .error       (error),
      .err_code    (err_code),
      .prog_len    (prog_len)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [3:0]        data;
   } wr_t;

   int   total = 0;
   int   bad = 0;
   wr_t  exp_q[$];
   wr_t  wr_log[$];
   wr_t  cw;
   int   n_writes = 0;
   logic prev_w = 1'b0;
   bit   exp_done;
   bit   exp_err;
   int   exp_code;
   int   exp_len;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int decode(input byte c);
      case (c)
         8'h3E:   return 0;
         8'h3C:   return 1;
         8'h2B:   return 2;
         8'h2D:   return 3;
         8'h2E:   return 4;
         8'h2C:   return 5;
         8'h5B:   return 6;
         8'h5D:   return 7;
         default: return -1;
      endcase
   endfunction

   // Source-text model: walks the characters in order and records the
   // writes and final status a correct loader must produce.
   task automatic model(input string s, input bit end_last, input bit end_after);
      int depth;
      int len;
      bit comment;
      bit stop;
      depth = 0;
      len = 0;
      comment = 0;
      stop = 0;
      exp_done = 0;
      exp_err = 0;
      exp_code = 0;
      for (int i = 0; i < s.len() && !stop; i++) begin
         byte c;
         bit  e;
         int  op;
         c  = s[i];
         e  = end_last && (i == s.len() - 1);
         op = decode(c);
         if (comment) begin
            if (c == 8'h0A) comment = 0;
         end else if (op < 0) begin
`ifdef BF_LOADER_COMMENT_EN
            if (c == 8'h23) comment = 1;
`endif
         end else if (op == 7 && depth == 0) begin
            exp_err = 1; exp_code = 1; stop = 1;
         end else if (op == 6 && depth == (1 << NEST_W) - 1) begin
            exp_err = 1; exp_code = 3; stop = 1;
         end else if (len == (1 << ADDR_W)) begin
            exp_err = 1; exp_code = 3; stop = 1;
         end else begin
            exp_q.push_back(wr_t'({ADDR_W'(len), 4'(op)}));
            len++;
            if (op == 6) depth++;
            if (op == 7) depth--;
         end
         if (!stop && e) begin
            if (depth != 0) begin exp_err = 1; exp_code = 2; end
            else exp_done = 1;
            stop = 1;
         end
      end
      if (!stop && end_after) begin
         if (depth != 0) begin exp_err = 1; exp_code = 2; end
         else exp_done = 1;
      end
      exp_len = len;
   endtask

   // Write monitor: every strobe must match the next expected write and be one cycle wide.
   always @(negedge clock) begin
      if (reset_n) begin
         if (instr_write) begin
            n_writes++;
            wr_log.push_back(wr_t'({instr_addr, instr_data}));
            check("write_width", prev_w, 0);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", instr_addr, instr_data);
            end else begin
               cw = exp_q.pop_front();
               check("write_addr", instr_addr, cw.addr);
               check("write_data", instr_data, cw.data);
            end
         end
         check("cpu_reset_vs_done", cpu_reset, !done);
         prev_w = instr_write;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic restart();
      start = 1'b1;
      step();
      start = 1'b0;
      exp_q.delete();
      wr_log.delete();
      n_writes = 0;
   endtask

   task automatic send(input byte c, input bit e);
      bit sent;
      sent = 0;
      char_in = c;
      char_valid = 1'b1;
      src_end = e;
      for (int n = 0; n < 16 && !sent; n++) begin
         if (done || error) break;
         if (char_ready) sent = 1;
         step();
      end
      char_valid = 1'b0;
      src_end = 1'b0;
      if (!sent && !(done || error)) begin
         total++;
         bad++;
         $display("FAIL handshake_timeout: got char_ready=%0b expected 1 within 16 cycles", char_ready);
      end
   endtask

   task automatic send_str(input string s, input bit end_last);
      for (int i = 0; i < s.len(); i++)
         send(s[i], end_last && (i == s.len() - 1));
   endtask

   task automatic end_pulse();
      for (int n = 0; n < 16; n++) begin
         if (done || error || char_ready) break;
         step();
      end
      if (!(done || error)) begin
         src_end = 1'b1;
         step();
         src_end = 1'b0;
      end
   endtask

   task automatic finish_test(input string name);
      for (int n = 0; n < 40; n++) begin
         if (done || error) break;
         step();
      end
      step();
      check({name, "_done"}, done, exp_done);
      check({name, "_error"}, error, exp_err);
      check({name, "_err_code"}, err_code, exp_code);
      check({name, "_prog_len"}, prog_len, exp_len);
      check({name, "_cpu_reset"}, cpu_reset, !exp_done);
      check({name, "_writes_left"}, exp_q.size(), 0);
      check({name, "_n_writes"}, n_writes, exp_len);
   endtask

   task automatic run(input string name, input string s, input bit end_last, input bit end_after);
      restart();
      model(s, end_last, end_after);
      send_str(s, end_last);
      if (end_after) end_pulse();
      finish_test(name);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      string s;
      repeat (3) step();
      reset_n = 1'b1;
      step();
      check("rst_addr", instr_addr, 0);
      check("rst_data", instr_data, 0);
      check("rst_write", instr_write, 0);
      check("rst_cpu_reset", cpu_reset, 1);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_err_code", err_code, 0);
      check("rst_prog_len", prog_len, 0);
      check("rst_ready", char_ready, 1);

      // Balanced loop program.
      run("loop", "+[->+<].", 0, 1);
      check("loop_len_lit", prog_len, 8);
      check("loop_pulses_lit", n_writes, 8);
      check("loop_d1_lit", wr_log[1].data, 6);
      check("loop_d6_lit", wr_log[6].data, 7);
      check("loop_a7_lit", wr_log[7].addr, 7);

      // Ignored bytes, src_end on the last command.
      run("filter", "a+ b\n-", 1, 0);
      check("filter_len_lit", prog_len, 2);
      check("filter_d0_lit", wr_log[0].data, 2);
      check("filter_d1_lit", wr_log[1].data, 3);
      check("filter_a1_lit", wr_log[1].addr, 1);

      // Stray close bracket after one command.
      run("stray", "+]", 0, 0);
      check("stray_code_lit", err_code, 2'b01);
      check("stray_writes_lit", n_writes, 1);

      // Close bracket as the very first command.
      run("stray0", "]", 0, 0);

      // Unclosed brackets at end of source.
      run("unclosed", "[[+", 1, 0);
      check("unclosed_code_lit", err_code, 2'b10);

      // Empty program: src_end alone.
      run("empty", "", 0, 1);

      // Capacity: 256 commands fit, the 257th is rejected.
      s = "";
      for (int i = 0; i < 256; i++) s = {s, "+"};
      s = {s, ">"};
      run("cap", s, 0, 0);
      check("cap_code_lit", err_code, 2'b11);
      check("cap_len_lit", prog_len, 256);
      check("cap_last_addr_lit", wr_log[255].addr, 255);

      // Exactly full program still completes.
      s = "";
      for (int i = 0; i < 256; i++) s = {s, "-"};
      run("full", s, 1, 0);

      // Nesting depth: 16th open bracket is rejected.
      s = "";
      for (int i = 0; i < 16; i++) s = {s, "["};
      run("nest", s, 0, 0);
      check("nest_code_lit", err_code, 2'b11);
      check("nest_len_lit", prog_len, 15);

      // start during the strobe of the third command.
      restart();
      exp_q.push_back(wr_t'({ADDR_W'(0), 4'd2}));
      exp_q.push_back(wr_t'({ADDR_W'(1), 4'd2}));
      exp_q.push_back(wr_t'({ADDR_W'(2), 4'd2}));
      send("+", 0);
      send("+", 0);
      send("+", 0);
      step();
      check("abort_in_strobe", instr_write, 1);
      start = 1'b1;
      step();
      start = 1'b0;
      check("abort_write_low", instr_write, 0);
      check("abort_prog_len", prog_len, 0);
      check("abort_cpu_reset", cpu_reset, 1);
      check("abort_writes_left", exp_q.size(), 0);
      wr_log.delete();
      n_writes = 0;
      exp_q.push_back(wr_t'({ADDR_W'(0), 4'd3}));
      exp_done = 1; exp_err = 0; exp_code = 0; exp_len = 1;
      send("-", 1);
      finish_test("abort");
      check("abort_addr_lit", wr_log[0].addr, 0);

      // Comment handling ('#' is an ordinary ignored byte without the feature).
      run("comment", "+#+-\n-", 1, 0);
`ifdef BF_LOADER_COMMENT_EN
      check("comment_writes_lit", n_writes, 2);
`else
      check("comment_writes_lit", n_writes, 4);
`endif

      // Sticky DONE ignores further characters.
      run("sticky", "+", 0, 1);
      send("+", 0);
      check("sticky_len", prog_len, 1);
      check("sticky_done", done, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
